// File: rtl/seq_serializer.sv
// Parallel-to-serial source stage: a small FIFO of words shifted out MSB-first on prtx,
// frames back-to-back. Define SER_PARITY_EN to append an even-parity bit to every frame.
module seq_serializer #(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_vld,
  output logic                     din_rdy,
  output logic                     prtx,
  output logic                     prtx_vld,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef SER_PARITY_EN
    S_PAR,
`endif
    S_SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               prtx_q, prtx_d;
  logic               prtx_vld_q, prtx_vld_d;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;

  logic               push, pop, load, go_idle, have_word;
  logic [WIDTH-1:0]   head;

  // Readiness comes from registered occupancy only, so a same-edge pop never frees a full FIFO.
  assign din_rdy   = (level_q != LVL_W'(DEPTH));
  assign push      = din_vld && din_rdy;
  assign have_word = (level_q != '0);
  assign head      = mem[rd_ptr_q];

  // NOTE: every variable written here gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    prtx_d     = prtx_q;
    prtx_vld_d = prtx_vld_q;
    load       = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (have_word) load = 1'b1;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          prtx_d = shreg_q[cnt_q - 1'b1];
        end else begin
`ifdef SER_PARITY_EN
          state_d    = S_PAR;
          prtx_d     = ^shreg_q;
          prtx_vld_d = 1'b1;
`else
          if (have_word) load = 1'b1;
          else           go_idle = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        if (have_word) load = 1'b1;
        else           go_idle = 1'b1;
      end
`endif
      default: go_idle = 1'b1;
    endcase

    // Loading a new word always starts a frame with its MSB on the same edge as the pop.
    if (load) begin
      state_d    = S_SHIFT;
      shreg_d    = head;
      cnt_d      = CNT_W'(WIDTH - 1);
      prtx_d     = head[WIDTH-1];
      prtx_vld_d = 1'b1;
    end else if (go_idle) begin
      state_d    = S_IDLE;
      prtx_d     = IDLE_BIT;
      prtx_vld_d = 1'b0;
    end
  end

  assign pop = load;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      prtx_q     <= IDLE_BIT;
      prtx_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      prtx_q     <= prtx_d;
      prtx_vld_q <= prtx_vld_d;
    end
  end

  // NOTE: the storage array is not reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign prtx     = prtx_q;
  assign prtx_vld = prtx_vld_q;
  assign level    = level_q;
  assign busy     = (state_q != S_IDLE) || have_word;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer (WIDTH=4, DEPTH=4): directed steps plus random traffic,
// compared every cycle against a queue-based model of words and pending line bits.
module tb_seq_serializer;

  localparam int   W     = 4;
  localparam int   D     = 4;
  localparam logic IDLE  = 1'b0;
  localparam int   LVL_W = $clog2(D) + 1;

  logic             clk;
  logic             rst;
  logic [W-1:0]     din;
  logic             din_vld;
  logic             din_rdy;
  logic             prtx;
  logic             prtx_vld;
  logic             busy;
  logic [LVL_W-1:0] level;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fifo_m [$];
  bit           line_m [$];

  seq_serializer #(.WIDTH(W), .DEPTH(D), .IDLE_BIT(IDLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .prtx     (prtx),
    .prtx_vld (prtx_vld),
    .busy     (busy),
    .level    (level)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Each cycle the line carries the head of line_m; once it is consumed and nothing remains,
  // the next queued word (as held before this edge) becomes a fresh frame.
  task automatic model_edge(input logic [W-1:0] d, input logic v);
    bit           accept;
    logic [W-1:0] w;
    accept = v && (fifo_m.size() < D);
    if (line_m.size() > 0) void'(line_m.pop_front());
    if (line_m.size() == 0 && fifo_m.size() > 0) begin
      w = fifo_m.pop_front();
      for (int i = W - 1; i >= 0; i--) line_m.push_back(w[i]);
`ifdef SER_PARITY_EN
      line_m.push_back(^w);
`endif
    end
    if (accept) fifo_m.push_back(d);
  endtask

  task automatic model_reset();
    fifo_m.delete();
    line_m.delete();
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".prtx"},     32'(prtx),     32'(line_m.size() > 0 ? line_m[0] : IDLE));
    check({tag, ".prtx_vld"}, 32'(prtx_vld), 32'(line_m.size() > 0));
    check({tag, ".level"},    32'(level),    32'(fifo_m.size()));
    check({tag, ".din_rdy"},  32'(din_rdy),  32'(fifo_m.size() != D));
    check({tag, ".busy"},     32'(busy),     32'(line_m.size() > 0 || fifo_m.size() > 0));
  endtask

  task automatic step(input string tag, input logic [W-1:0] d, input logic v);
    din     = d;
    din_vld = v;
    @(posedge clk);
    model_edge(d, v);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rv;

    rst     = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    model_reset();

    // Reset held for 15 ns, observed before and after the first edge.
    #2;  compare_all("reset_a");
    #10; compare_all("reset_b");
    #3;  rst = 1'b1;
    idle("post_reset", 3);

    step("single_push", 4'b1010, 1'b1);
    idle("single", 8);

    step("b2b_push0", 4'b1010, 1'b1);
    step("b2b_push1", 4'b0101, 1'b1);
    idle("b2b", 14);

    for (int i = 0; i < 6; i++) step("full_push", W'(4'h3 + i), 1'b1);
    for (int i = 0; i < 10; i++) step("full_hold", 4'hF - W'(i), 1'b1);
    idle("full_drain", 30);

    step("par_push0", 4'b1011, 1'b1);
    idle("par0", 7);
    step("par_push1", 4'b1001, 1'b1);
    idle("par1", 7);

    // Reset while bit 2 of 4'b1100 is on the line and two words are queued.
    step("rmf_push0", 4'b1100, 1'b1);
    step("rmf_push1", 4'b0011, 1'b1);
    step("rmf_push2", 4'b0110, 1'b1);
    din_vld = 1'b0;
    check("rmf.queued", 32'(level), 32'd2);
    #3; rst = 1'b0;
    #1; model_reset();
    compare_all("rmf_in_reset");
    #2; rst = 1'b1;
    idle("rmf_after", 12);

    for (int i = 0; i < 600; i++) begin
      rd = W'($urandom);
      rv = ((i % 150) < 100) ? ($urandom_range(0, 3) != 0) : 1'b0;
      step("random", rd, rv);
    end
    idle("final_drain", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
